// File: rtl/model_scalar_integer_divider_pkg.sv
// Shared constants and state encoding for the scalar restoring divider.
package model_scalar_integer_divider_pkg;

  typedef enum logic [1:0] {
    STARTER_STATE = 2'd0,
    COMPUTE_STATE = 2'd1,
    ENDER_STATE   = 2'd2
  } state_t;

  localparam int ZERO_CONTROL = 0;
  localparam int ONE_CONTROL  = 1;
  localparam int ZERO_DATA    = 0;
  localparam int ONE_DATA     = 1;

endpackage

// File: rtl/model_scalar_integer_divider_if.sv
// Request/result bundle between a divider client and the scalar divider.
interface model_scalar_integer_divider_if #(
  parameter int DATA_SIZE = 64
);
  import model_scalar_integer_divider_pkg::*;

  logic                 START;
  logic                 READY;
  logic [DATA_SIZE-1:0] DATA_A_IN;
  logic [DATA_SIZE-1:0] DATA_B_IN;
  logic [DATA_SIZE-1:0] DATA_OUT;
  logic [DATA_SIZE-1:0] REST_OUT;
  logic                 DIV_BY_ZERO_OUT;

  modport master (
    output START, DATA_A_IN, DATA_B_IN,
    input  READY, DATA_OUT, REST_OUT, DIV_BY_ZERO_OUT
  );

  modport slave (
    input  START, DATA_A_IN, DATA_B_IN,
    output READY, DATA_OUT, REST_OUT, DIV_BY_ZERO_OUT
  );

endinterface

// File: rtl/model_scalar_integer_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// fixed latency regardless of operands (divide-by-zero included).
module model_scalar_integer_divider
  import model_scalar_integer_divider_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input logic CLK,
  input logic RST,
  model_scalar_integer_divider_if.slave bus
);

  state_t state;
  state_t state_next;

  logic [CONTROL_SIZE-1:0] counter;
  logic [DATA_SIZE-1:0]    quotient;
  logic [DATA_SIZE-1:0]    divisor;
  // One extra bit so the shifted partial remainder never overflows the compare.
  logic [DATA_SIZE:0]      remainder;
  logic                    zero_flag;

  logic [DATA_SIZE-1:0]    data_out_r;
  logic [DATA_SIZE-1:0]    rest_out_r;
  logic                    dbz_r;
  logic                    ready_r;

  logic [DATA_SIZE:0]      shifted;
  logic [DATA_SIZE:0]      remainder_next;
  logic [DATA_SIZE-1:0]    quotient_next;
  logic                    last_iteration;

  assign last_iteration = (counter == CONTROL_SIZE'(DATA_SIZE - 1));

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= STARTER_STATE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; unused encoding falls back to the idle state.
  always_comb begin
    state_next = state;
    case (state)
      STARTER_STATE: if (bus.START) state_next = COMPUTE_STATE;
      COMPUTE_STATE: if (last_iteration) state_next = ENDER_STATE;
      ENDER_STATE:   state_next = STARTER_STATE;
      default:       state_next = STARTER_STATE;
    endcase
  end

  // Single restoring iteration: shift in the next dividend bit, trial subtract.
  always_comb begin
    // The remainder MSB is always zero here, so the shift drops nothing.
    shifted = (remainder << 1) | {{DATA_SIZE{1'b0}}, quotient[DATA_SIZE-1]};
    if (shifted >= {1'b0, divisor}) begin
      remainder_next = shifted - {1'b0, divisor};
      quotient_next  = {quotient[DATA_SIZE-2:0], 1'b1};
    end else begin
      remainder_next = shifted;
      quotient_next  = {quotient[DATA_SIZE-2:0], 1'b0};
    end
  end

  // Datapath, iteration counter and registered results.
  always_ff @(posedge CLK) begin
    if (RST) begin
      counter    <= CONTROL_SIZE'(ZERO_CONTROL);
      quotient   <= DATA_SIZE'(ZERO_DATA);
      divisor    <= DATA_SIZE'(ZERO_DATA);
      remainder  <= (DATA_SIZE + 1)'(ZERO_DATA);
      zero_flag  <= 1'b0;
      data_out_r <= DATA_SIZE'(ZERO_DATA);
      rest_out_r <= DATA_SIZE'(ZERO_DATA);
      dbz_r      <= 1'b0;
      ready_r    <= 1'b0;
    end else begin
      case (state)
        STARTER_STATE: begin
          ready_r <= 1'b0;
          if (bus.START) begin
            quotient  <= bus.DATA_A_IN;
            divisor   <= bus.DATA_B_IN;
            remainder <= (DATA_SIZE + 1)'(ZERO_DATA);
            counter   <= CONTROL_SIZE'(ZERO_CONTROL);
            zero_flag <= (bus.DATA_B_IN == DATA_SIZE'(ZERO_DATA));
          end
        end
        COMPUTE_STATE: begin
          quotient  <= quotient_next;
          remainder <= remainder_next;
          counter   <= counter + CONTROL_SIZE'(ONE_CONTROL);
        end
        ENDER_STATE: begin
          data_out_r <= quotient;
          rest_out_r <= remainder[DATA_SIZE-1:0];
          dbz_r      <= zero_flag;
          ready_r    <= 1'b1;
        end
        default: begin
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.READY           = ready_r;
  assign bus.DATA_OUT        = data_out_r;
  assign bus.REST_OUT        = rest_out_r;
  assign bus.DIV_BY_ZERO_OUT = dbz_r;

endmodule

// File: tb/tb_model_scalar_integer_divider.sv
// Directed and random checks of the scalar divider through a result scoreboard.
module tb_model_scalar_integer_divider;

  localparam int W   = 64;
  localparam int LAT = W + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           t_acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;
  int   ready_seen = 0;
  logic prev_ready = 1'b0;
  exp_t sb[$];

  logic [W-1:0] all_ones;

  model_scalar_integer_divider_if #(.DATA_SIZE(W)) bus ();

  model_scalar_integer_divider #(.DATA_SIZE(W), .CONTROL_SIZE(64)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive a request so it is sampled on the next rising edge.
  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b, input bit push,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic ed);
    exp_t e;
    bus.START     = 1'b1;
    bus.DATA_A_IN = a;
    bus.DATA_B_IN = b;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    bus.DATA_A_IN = ~a;
    bus.DATA_B_IN = ~b;
    if (push) begin
      e.q = eq; e.r = er; e.dbz = ed; e.t_acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4 * LAT; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("result_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Result monitor: pops the scoreboard on every READY.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.READY === 1'b1) begin
        ready_seen++;
        chk("ready_width", {63'd0, prev_ready}, 64'd0);
        chk("ready_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("quotient", bus.DATA_OUT, e.q);
          chk("remainder", bus.REST_OUT, e.r);
          chk("div_by_zero", {63'd0, bus.DIV_BY_ZERO_OUT}, {63'd0, e.dbz});
          chk("latency", 64'(cyc), 64'(e.t_acc + LAT));
        end
      end
      prev_ready = bus.READY;
    end
  end

  initial begin
    logic [W-1:0] a, b;
    int snap;
    all_ones = '1;
    bus.START = 1'b0;
    bus.DATA_A_IN = '0;
    bus.DATA_B_IN = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {63'd0, bus.READY}, 64'd0);
    chk("rst_data_out", bus.DATA_OUT, 64'd0);
    chk("rst_rest_out", bus.REST_OUT, 64'd0);
    chk("rst_dbz", {63'd0, bus.DIV_BY_ZERO_OUT}, 64'd0);

    // Basic and extremes
    do_start(64'd100, 64'd7, 1, 64'd14, 64'd2, 1'b0);
    wait_idle();
    do_start(64'd3, 64'd10, 1, 64'd0, 64'd3, 1'b0);
    wait_idle();
    do_start(all_ones, 64'd1, 1, all_ones, 64'd0, 1'b0);
    wait_idle();

    // Divide by zero, then the flag clears
    do_start(64'd5, 64'd0, 1, all_ones, 64'd5, 1'b1);
    wait_idle();
    do_start(64'd9, 64'd3, 1, 64'd3, 64'd0, 1'b0);
    wait_idle();

    // START while busy is ignored; START in the READY cycle is accepted
    do_start(64'd100, 64'd7, 1, 64'd14, 64'd2, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    bus.START = 1'b1; bus.DATA_A_IN = 64'd50; bus.DATA_B_IN = 64'd5;
    repeat (5) @(posedge clk);
    #1 bus.START = 1'b0;
    for (int i = 0; i < 2 * LAT; i++) begin
      @(negedge clk);
      if (bus.READY === 1'b1) break;
    end
    chk("b2b_ready_seen", {63'd0, bus.READY}, 64'd1);
    do_start(64'd50, 64'd5, 1, 64'd10, 64'd0, 1'b0);
    wait_idle();

    // Reset in the middle of an operation discards it
    do_start(64'd100, 64'd7, 0, '0, '0, 1'b0);
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_ready", {63'd0, bus.READY}, 64'd0);
    chk("midrst_data_out", bus.DATA_OUT, 64'd0);
    chk("midrst_rest_out", bus.REST_OUT, 64'd0);
    chk("midrst_dbz", {63'd0, bus.DIV_BY_ZERO_OUT}, 64'd0);
    snap = ready_seen;
    repeat (LAT + 15) @(negedge clk);
    chk("midrst_no_ready", 64'(ready_seen), 64'(snap));
    do_start(64'd81, 64'd9, 1, 64'd9, 64'd0, 1'b0);
    wait_idle();

    // Random regression, mixing narrow and full-width operands
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) begin
        a = 64'($urandom_range(255, 0));
        b = 64'($urandom_range(255, 1));
      end else begin
        a = {$urandom, $urandom};
        b = (i % 3 == 0) ? 64'($urandom_range(1000, 1)) : {$urandom, $urandom};
        if (b == 64'd0) b = 64'd1;
      end
      do_start(a, b, 1, a / b, a % b, 1'b0);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
